alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets four requesters share one external 8-bit ALU.
// Handles one request at a time: accept, issue to the ALU, wait for the result
// or a timeout, then send the response back to the requester.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_req_valid,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  input  logic [7:0]  i_req_op,
  output logic [3:0]  o_req_ready,
  output logic [3:0]  o_rsp_valid,
  output logic [7:0]  o_rsp_result,
  output logic [1:0]  o_rsp_id,
  output logic        o_alu_valid,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic [1:0]  o_alu_op,
  input  logic        i_alu_valid,
  input  logic [7:0]  i_alu_result,
  output logic        o_busy,
  output logic        o_timeout_err,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a request transfers on a rising edge where i_req_valid[n] and
  // o_req_ready[n] are both high; o_rsp_valid and o_alu_valid are one-cycle
  // strobes with no back-pressure.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_ptr;
  logic [1:0]  r_id;
  logic [1:0]  r_op;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [7:0]  r_wcnt;
  logic [7:0]  r_rsp_result;
  logic [1:0]  r_rsp_id;
  logic        r_timeout_err;
  logic        w_win_found;
  logic [1:0]  w_win_id;
  logic        w_accept;
  logic        w_timeout;

  // Rotating priority search starting at r_ptr.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_win_found && i_req_valid[2'(r_ptr + 2'(i))]) begin
        w_win_found = 1'b1;
        w_win_id    = 2'(r_ptr + 2'(i));
      end
    end
  end

  always_comb begin
    o_req_ready = 4'b0000;
    if (r_state == S_IDLE && w_win_found && !i_rst) begin
      o_req_ready = 4'b0001 << w_win_id;
    end
  end

  assign w_accept  = |(o_req_ready & i_req_valid);
  assign w_timeout = !i_alu_valid && (r_wcnt == 8'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (i_alu_valid || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= 2'd0;
      r_id          <= 2'd0;
      r_op          <= 2'd0;
      r_a           <= 8'd0;
      r_b           <= 8'd0;
      r_wcnt        <= 8'd0;
      r_rsp_result  <= 8'd0;
      r_rsp_id      <= 2'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= 8'd0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id <= w_win_id;
            r_a  <= i_req_a[{w_win_id, 3'b000} +: 8];
            r_b  <= i_req_b[{w_win_id, 3'b000} +: 8];
            r_op <= i_req_op[{w_win_id, 1'b0} +: 2];
          end
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + 8'd1;
          // A real result on the timeout cycle takes priority over the abort.
          if (i_alu_valid) begin
            r_rsp_result <= i_alu_result;
            r_rsp_id     <= r_id;
          end else if (w_timeout) begin
            r_rsp_result  <= 8'hFF;
            r_rsp_id      <= r_id;
            r_timeout_err <= 1'b1;
          end
        end
        S_RESP: r_ptr <= r_id + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_rsp_valid = 4'b0000;
    if (r_state == S_RESP) begin
      o_rsp_valid = 4'b0001 << r_rsp_id;
    end
  end

  assign o_rsp_result  = r_rsp_result;
  assign o_rsp_id      = r_rsp_id;
  assign o_alu_valid   = (r_state == S_ISSUE);
  assign o_alu_a       = r_a;
  assign o_alu_b       = r_b;
  assign o_alu_op      = r_op;
  assign o_busy        = (r_state != S_IDLE);
  assign o_timeout_err = r_timeout_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a vector table of single requests plus hand-written
// sequences for arbitration order, timeout, reset abort and stray ALU strobes.
module tb_alu_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_req_valid;
  logic [31:0] i_req_a;
  logic [31:0] i_req_b;
  logic [7:0]  i_req_op;
  logic [3:0]  o_req_ready;
  logic [3:0]  o_rsp_valid;
  logic [7:0]  o_rsp_result;
  logic [1:0]  o_rsp_id;
  logic        o_alu_valid;
  logic [7:0]  o_alu_a;
  logic [7:0]  o_alu_b;
  logic [1:0]  o_alu_op;
  logic        i_alu_valid;
  logic [7:0]  i_alu_result;
  logic        o_busy;
  logic        o_timeout_err;
  logic [1:0]  o_dbg_state;

  alu_arbiter #(.NUM_REQ(4), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_op(i_req_op),
    .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_result(o_rsp_result),
    .o_rsp_id(o_rsp_id), .o_alu_valid(o_alu_valid), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .o_alu_op(o_alu_op), .i_alu_valid(i_alu_valid), .i_alu_result(i_alu_result),
    .o_busy(o_busy), .o_timeout_err(o_timeout_err), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rsp_count = 0;
  int          rsp_cyc = -1;
  int          issue_cyc = -1;
  logic [3:0]  last_ready;
  logic [9:0]  exp_q[$];      // {id, result}
  int          grant_id_q[$];
  int          grant_cyc_q[$];
  int          stub_mode;     // 0 = 1-cycle ALU, 1 = silent, 2 = manual
  logic        man_v;
  logic [7:0]  man_r;
  logic        pend;
  logic [7:0]  pend_r;

  typedef struct {
    logic [1:0] id;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a ^ b;
      2'd2:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample accept before the edge, then drive the ALU stub and
  // score any response just after the edge.
  task automatic tick();
    logic [3:0] acc;
    logic [9:0] e;
    #1;
    acc = i_rst ? 4'b0000 : (o_req_ready & i_req_valid);
    if (acc != 4'b0000) begin
      last_ready = o_req_ready;
      for (int i = 3; i >= 0; i--) begin
        if (acc[i]) e[1:0] = 2'(i);
      end
      grant_id_q.push_back(int'(e[1:0]));
      grant_cyc_q.push_back(cyc);
    end
    @(posedge i_clk);
    #1;
    cyc++;
    if (stub_mode == 2) begin
      i_alu_valid  = man_v;
      i_alu_result = man_r;
    end else begin
      i_alu_valid  = pend;
      i_alu_result = pend_r;
    end
    pend   = (stub_mode == 0) && o_alu_valid;
    pend_r = alu_f(o_alu_a, o_alu_b, o_alu_op);
    if (o_alu_valid) issue_cyc = cyc;
    if (o_rsp_valid != 4'b0000) begin
      rsp_cyc = cyc;
      rsp_count++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", o_rsp_valid, 4'b0000);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_valid", o_rsp_valid, 4'b0001 << e[9:8]);
        chk("rsp_id", o_rsp_id, e[9:8]);
        chk("rsp_result", o_rsp_result, e[7:0]);
      end
    end
  endtask

  task automatic do_reset();
    i_rst       = 1'b1;
    i_req_valid = 4'b0000;
    tick();
    i_rst = 1'b0;
    exp_q.delete();
    pend = 1'b0;
  endtask

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op);
    i_req_a[8*id +: 8]  = a;
    i_req_b[8*id +: 8]  = b;
    i_req_op[2*id +: 2] = op;
  endtask

  task automatic run_grants(input int count, input int budget);
    int target;
    int n;
    target = grant_id_q.size() + count;
    n = 0;
    while (grant_id_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    chk("grant_budget", grant_id_q.size() >= target, 1);
  endtask

  // Raises one request, holds it until accepted, then withdraws it.
  task automatic do_req(input int id, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, output int gcyc);
    int start;
    start = grant_id_q.size();
    set_ops(id, a, b, op);
    i_req_valid[id] = 1'b1;
    run_grants(1, 20);
    i_req_valid[id] = 1'b0;
    gcyc = -1;
    if (grant_id_q.size() > start) begin
      gcyc = grant_cyc_q[start];
      chk("grant_id", grant_id_q[start], id);
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n;
    n = 0;
    while (rsp_count < target && n < budget) begin
      tick();
      n++;
    end
    chk("rsp_budget", rsp_count >= target, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int g;
    int s;
    int r0;
    logic [7:0] ea;

    vecs[0] = '{2'd0, 8'h0F, 8'h01, 2'd0, 8'h10};
    vecs[1] = '{2'd1, 8'hF0, 8'h33, 2'd1, 8'hC3};
    vecs[2] = '{2'd2, 8'h0A, 8'h50, 2'd2, 8'h5A};
    vecs[3] = '{2'd3, 8'h3C, 8'h0F, 2'd3, 8'h0C};
    vecs[4] = '{2'd1, 8'hFF, 8'h02, 2'd0, 8'h01};
    vecs[5] = '{2'd3, 8'hAA, 8'h55, 2'd1, 8'hFF};

    i_rst = 1'b1; i_req_valid = 4'b0000; i_req_a = '0; i_req_b = '0; i_req_op = '0;
    i_alu_valid = 1'b0; i_alu_result = 8'h00;
    stub_mode = 0; man_v = 1'b0; man_r = 8'h00; pend = 1'b0; pend_r = 8'h00;
    last_ready = 4'b0000;

    // Reset: ready stays low while reset is high even with all requests up.
    tick();
    i_req_valid = 4'b1111;
    #1;
    chk("ready_in_reset", o_req_ready, 4'b0000);
    tick();
    i_req_valid = 4'b0000;
    i_rst = 1'b0;
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_alu_valid", o_alu_valid, 0);
    chk("rst_rsp_result", o_rsp_result, 0);
    chk("rst_rsp_id", o_rsp_id, 0);
    chk("rst_alu_ops", {o_alu_a, o_alu_b, o_alu_op}, 0);
    chk("rst_timeout_err", o_timeout_err, 0);

    // Table of single requests: latency, one-hot ready, held outputs.
    for (int k = 0; k < 6; k++) begin
      r0 = rsp_count;
      exp_q.push_back({vecs[k].id, vecs[k].exp});
      do_req(int'(vecs[k].id), vecs[k].a, vecs[k].b, vecs[k].op, g);
      chk("vec_ready", last_ready, 4'b0001 << vecs[k].id);
      wait_rsp(r0 + 1, 10);
      chk("vec_issue_lat", issue_cyc, g + 1);
      chk("vec_rsp_lat", rsp_cyc, g + 3);
      tick();
      chk("vec_rsp_clear", o_rsp_valid, 0);
      chk("vec_rsp_hold", o_rsp_result, vecs[k].exp);
      chk("vec_alu_hold", {o_alu_a, o_alu_b, o_alu_op}, {vecs[k].a, vecs[k].b, vecs[k].op});
    end

    // All four requesters held valid after reset: 0,1,2,3,0 four cycles apart.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_ops(k, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({2'(k % 4), alu_f(i_req_a[8*(k%4) +: 8], i_req_b[8*(k%4) +: 8],
                                        i_req_op[2*(k%4) +: 2])});
    end
    s  = grant_id_q.size();
    r0 = rsp_count;
    i_req_valid = 4'b1111;
    run_grants(5, 40);
    i_req_valid = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      if (grant_id_q.size() > s + k) begin
        chk("rr_order", grant_id_q[s+k], k % 4);
        if (k > 0) chk("rr_spacing", grant_cyc_q[s+k] - grant_cyc_q[s+k-1], 4);
      end
    end
    wait_rsp(r0 + 5, 20);

    // Serve req2 (ptr -> 3), then req2+req3 together: 3 first, then 2.
    r0 = rsp_count;
    exp_q.push_back({2'd2, alu_f(8'h21, 8'h12, 2'd0)});
    do_req(2, 8'h21, 8'h12, 2'd0, g);
    wait_rsp(r0 + 1, 10);
    set_ops(2, 8'h40, 8'h04, 2'd2);
    set_ops(3, 8'h77, 8'h0F, 2'd3);
    exp_q.push_back({2'd3, 8'h07});
    exp_q.push_back({2'd2, 8'h44});
    s = grant_id_q.size();
    i_req_valid = 4'b1100;
    run_grants(1, 10);
    i_req_valid = 4'b0100;
    run_grants(1, 10);
    i_req_valid = 4'b0000;
    if (grant_id_q.size() >= s + 2) begin
      chk("ptr3_first", grant_id_q[s], 3);
      chk("ptr3_second", grant_id_q[s+1], 2);
    end
    wait_rsp(r0 + 3, 20);

    // Silent ALU: abort 15 cycles after entering WAIT, sticky error.
    stub_mode = 1;
    r0 = rsp_count;
    exp_q.push_back({2'd1, 8'hFF});
    do_req(1, 8'h11, 8'h22, 2'd0, g);
    wait_rsp(r0 + 1, 30);
    chk("to_rsp_cycle", rsp_cyc, g + 17);
    chk("to_err_set", o_timeout_err, 1);
    stub_mode = 0;
    for (int k = 0; k < 2; k++) begin
      r0 = rsp_count;
      exp_q.push_back({2'(k), alu_f(8'h30, 8'h03, 2'(k))});
      do_req(k, 8'h30, 8'h03, 2'(k), g);
      wait_rsp(r0 + 1, 10);
    end
    chk("to_err_sticky", o_timeout_err, 1);

    // Reset during WAIT: no response, late ALU strobe ignored, ptr back to 0.
    r0 = rsp_count;
    exp_q.push_back({2'd1, alu_f(8'h05, 8'h06, 2'd1)});
    do_req(1, 8'h05, 8'h06, 2'd1, g);
    wait_rsp(r0 + 1, 10);
    stub_mode = 2;
    man_v = 1'b0;
    exp_q.push_back({2'd2, 8'h00});
    do_req(2, 8'h09, 8'h09, 2'd0, g);
    tick(); tick(); tick();
    chk("abort_in_wait", o_dbg_state, 2);
    chk("abort_busy_before", o_busy, 1);
    do_reset();
    chk("abort_busy_after", o_busy, 0);
    chk("abort_err_cleared", o_timeout_err, 0);
    r0 = rsp_count;
    man_v = 1'b1;
    man_r = 8'hAB;
    tick(); tick(); tick();
    man_v = 1'b0;
    tick();
    chk("abort_no_rsp", rsp_count, r0);
    chk("abort_idle", o_busy, 0);
    stub_mode = 0;
    set_ops(1, 8'h81, 8'h18, 2'd2);
    set_ops(3, 8'h01, 8'h01, 2'd0);
    exp_q.push_back({2'd1, 8'h99});
    s = grant_id_q.size();
    i_req_valid = 4'b1010;
    run_grants(1, 10);
    i_req_valid = 4'b0000;
    if (grant_id_q.size() > s) chk("abort_ptr0_grant", grant_id_q[s], 1);
    wait_rsp(r0 + 1, 10);

    // Stray ALU strobe in IDLE, then a result landing on the timeout cycle.
    stub_mode = 2;
    r0 = rsp_count;
    man_v = 1'b1;
    man_r = 8'h77;
    tick(); tick();
    man_v = 1'b0;
    tick();
    chk("stray_idle_busy", o_busy, 0);
    chk("stray_idle_no_rsp", rsp_count, r0);
    ea = 8'h5A;
    exp_q.push_back({2'd0, ea});
    do_req(0, 8'h01, 8'h02, 2'd0, g);
    while (cyc < g + 15) tick();
    man_v = 1'b1;
    man_r = ea;
    tick();
    man_v = 1'b0;
    wait_rsp(r0 + 1, 10);
    chk("coincide_rsp_cycle", rsp_cyc, g + 17);
    chk("coincide_no_err", o_timeout_err, 0);
    stub_mode = 0;
    tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
